serial_sub_ctrl: RTL and testbench

Bit-serial subtractor controller. It sequences a single 1-bit full-subtractor cell, built from two half subtractors, over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start handshake and reports the WIDTH-bit difference plus the final borrow with a one-cycle done pulse. It is the sequencing layer above the half/full subtractor datapath cells, trading area for WIDTH cycles of latency.

---
 rtl/serial_sub_ctrl_pkg.sv | 12 +
 rtl/serial_sub_ctrl_if.sv | 26 ++
 rtl/serial_sub_ctrl_full_sub_bit.sv | 31 +++
 rtl/serial_sub_ctrl.sv | 93 +++++++++
 tb/tb_serial_sub_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtractor slice.
package sub_pkg;

    localparam int unsigned DEFAULT_SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/operand request and result bundle between a requester and serial_sub_ctrl.
interface serial_sub_ctrl_if
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_SUB_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );

endinterface

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// 1-bit full subtractor cell assembled from two half subtractors.
module hs (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic b_o
);

    assign d_o = a_i ^ b_i;
    assign b_o = ~a_i & b_i;

endmodule

module full_sub_bit (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic d1;
    logic borrow1;
    logic borrow2;

    hs u_hs0 (.a_i(ai), .b_i(bi),  .d_o(d1), .b_o(borrow1));
    hs u_hs1 (.a_i(d1), .b_i(bin), .d_o(d),  .b_o(borrow2));

    assign bo = borrow1 | borrow2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Sequences one full_sub_bit cell over WIDTH bits, LSB first, one bit per clock.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_SUB_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_sub_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             borrow_q, borrow_d;
    logic             cell_d;
    logic             cell_bo;

    full_sub_bit u_cell (
        .ai  (a_q[0]),
        .bi  (b_q[0]),
        .bin (brw_q),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                // New bit enters at the MSB so diff is aligned after WIDTH steps.
                diff_d = (diff_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                brw_d  = cell_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    borrow_d = cell_bo;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Table-driven, scoreboarded bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
    } vec_t;

    typedef struct {
        logic [7:0]  diff;
        logic        borrow;
        int unsigned edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;
    int          n_done8 = 0;
    exp_t        q8[$];
    exp_t        q1[$];
    vec_t        vecs[8];
    vec_t        vecs1[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Advance to the next falling edge and retire any done pulse against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus8.done === 1'b1) begin
            n_done8++;
            if (q8.size() == 0) fail("unexpected done8");
            else begin
                e = q8.pop_front();
                check("diff8", bus8.diff, e.diff);
                check("borrow8", bus8.borrow, e.borrow);
                check("done8 edge", cyc, e.edge_n);
            end
        end
        if (bus1.done === 1'b1) begin
            if (q1.size() == 0) fail("unexpected done1");
            else begin
                e = q1.pop_front();
                check("diff1", bus1.diff, e.diff);
                check("borrow1", bus1.borrow, e.borrow);
                check("done1 edge", cyc, e.edge_n);
            end
        end
    endtask

    task automatic wait_idle(input bit w1);
        int i = 0;
        while (i < 40 && (w1 ? (bus1.busy || bus1.done) : (bus8.busy || bus8.done))) begin
            tick();
            i++;
        end
        if (i >= 40) fail("wait idle timeout");
    endtask

    task automatic start_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] ediff, input logic eborrow);
        exp_t e;
        wait_idle(w1);
        e.diff   = ediff;
        e.borrow = eborrow;
        e.edge_n = cyc + 1 + (w1 ? 1 : 8);
        if (w1) begin
            q1.push_back(e);
            bus1.a = a[0];
            bus1.b = b[0];
            bus1.start = 1'b1;
        end else begin
            q8.push_back(e);
            bus8.a = a;
            bus8.b = b;
            bus8.start = 1'b1;
        end
        tick();
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        check(w1 ? "busy1 after start" : "busy8 after start", w1 ? bus1.busy : bus8.busy, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q8.size() != 0 || q1.size() != 0); i++) tick();
        if (q8.size() != 0 || q1.size() != 0) begin
            fail("done timeout");
            q8.delete();
            q1.delete();
        end
    endtask

    initial begin
        int base;
        logic [7:0] ra, rb;
        logic [8:0] model;
        exp_t e;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
        vecs[7] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs1[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs1[1] = '{8'h00, 8'h01, 8'h01, 1'b1};
        vecs1[2] = '{8'h01, 8'h00, 8'h01, 1'b0};
        vecs1[3] = '{8'h01, 8'h01, 8'h00, 1'b0};

        // Reset held with start asserted.
        rst_n = 1'b0;
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01;
        bus1.start = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b0;
        tick();
        tick();
        check("rst busy8", bus8.busy, 0);
        check("rst done8", bus8.done, 0);
        check("rst diff8", bus8.diff, 0);
        check("rst borrow8", bus8.borrow, 0);
        check("rst busy1", bus1.busy, 0);
        check("rst done1", bus1.done, 0);
        check("rst diff1", bus1.diff, 0);
        check("rst borrow1", bus1.borrow, 0);
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle busy8", bus8.busy, 0);
        check("idle diff8", bus8.diff, 0);

        // Table vectors, each with a hold check after done.
        foreach (vecs[i]) begin
            start_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow);
            drain();
            repeat (3) tick();
            check("hold diff8", bus8.diff, vecs[i].diff);
            check("hold borrow8", bus8.borrow, vecs[i].borrow);
            check("idle busy8 post", bus8.busy, 0);
        end

        // Random operands checked against an unsigned 9-bit model.
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            model = {1'b0, ra} - {1'b0, rb};
            start_op(1'b0, ra, rb, model[7:0], model[8]);
            drain();
        end

        // start held high: back-to-back runs every WIDTH+2 cycles.
        wait_idle(1'b0);
        base = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e.diff = 8'h0F;
            e.borrow = 1'b0;
            e.edge_n = base + 8 + 10 * i;
            q8.push_back(e);
        end
        bus8.a = 8'h10;
        bus8.b = 8'h01;
        bus8.start = 1'b1;
        repeat (30) tick();
        bus8.start = 1'b0;
        drain();
        repeat (12) tick();
        check("held-start busy8 idle", bus8.busy, 0);

        // Reset during bit 4 of a run discards it.
        wait_idle(1'b0);
        bus8.a = 8'hC3;
        bus8.b = 8'h3C;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (4) tick();
        check("pre-rst busy8", bus8.busy, 1);
        base = n_done8;
        rst_n = 1'b0;
        #1;
        check("mid-rst busy8", bus8.busy, 0);
        check("mid-rst done8", bus8.done, 0);
        check("mid-rst diff8", bus8.diff, 0);
        check("mid-rst borrow8", bus8.borrow, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("no done after rst", n_done8, base);
        start_op(1'b0, 8'hC3, 8'h3C, 8'h87, 1'b0);
        drain();

        // WIDTH=1 instance, all four operand pairs.
        foreach (vecs1[i]) begin
            start_op(1'b1, vecs1[i].a, vecs1[i].b, vecs1[i].diff, vecs1[i].borrow);
            drain();
            tick();
            check("hold diff1", bus1.diff, vecs1[i].diff);
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
